// File: rtl/e_md_unit.sv
// e_md_unit -- execute-stage multiply/divide unit with architectural HI/LO.
//
// The unit runs mult/multu/div/divu as fixed-latency multicycle operations.
// The result is computed combinationally from the operands present at the
// start edge and parked in hi_tmp/lo_tmp. The countdown then runs, and on
// its last cycle the parked result is committed to HI/LO. mfhi/mflo read
// HI/LO combinationally. mthi/mtlo write HI/LO from rs while the unit is idle.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears all state
//   E_MD_op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//               7 mthi, 8 mtlo; 9-15 act as none
//   E_Fw_Grs    forwarded rs (dividend / multiplicand / mthi-mtlo source)
//   E_Fw_Grt    forwarded rt (divisor / multiplier)
//   E_MD_start  combinational: a mult/div op is being accepted this cycle
//   E_MD_busy   registered: an operation is in flight
//   E_MD_out    combinational: HI for mfhi, LO for mflo, else 0
//   HI, LO      architectural registers
module e_md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MD_op,
  input  logic [31:0] E_Fw_Grs,
  input  logic [31:0] E_Fw_Grt,
  output logic        E_MD_start,
  output logic        E_MD_busy,
  output logic [31:0] E_MD_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_tmp, lo_tmp;

  logic        is_md, is_mult, is_signed;
  logic [63:0] a64, b64, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;

  assign is_md     = (E_MD_op >= 4'd1) && (E_MD_op <= 4'd4);
  assign is_mult   = (E_MD_op == 4'd1) || (E_MD_op == 4'd2);
  assign is_signed = (E_MD_op == 4'd1) || (E_MD_op == 4'd3);

  assign E_MD_start = is_md && !E_MD_busy;

  // Stale HI/LO are returned while busy; the hazard unit keeps that from
  // ever mattering architecturally.
  always_comb begin
    E_MD_out = 32'd0;
    if (E_MD_op == 4'd5)      E_MD_out = HI;
    else if (E_MD_op == 4'd6) E_MD_out = LO;
  end

  // Multiply: extend to 64 bits according to signedness. The low 64 bits of
  // the product of the extended operands are the exact product either way.
  assign a64  = is_signed ? {{32{E_Fw_Grs[31]}}, E_Fw_Grs} : {32'd0, E_Fw_Grs};
  assign b64  = is_signed ? {{32{E_Fw_Grt[31]}}, E_Fw_Grt} : {32'd0, E_Fw_Grt};
  assign prod = a64 * b64;

  // Divide on magnitudes, then reapply signs. The quotient sign is the XOR
  // of the operand signs, and the remainder takes the dividend's sign.
  // 0x8000_0000 / -1 falls out naturally: |a| = 0x8000_0000, |b| = 1, and
  // both signs are negative, so q = 0x8000_0000 and r = 0.
  assign a_neg  = is_signed && E_Fw_Grs[31];
  assign b_neg  = is_signed && E_Fw_Grt[31];
  assign a_mag  = a_neg ? -E_Fw_Grs : E_Fw_Grs;
  assign b_mag  = b_neg ? -E_Fw_Grt : E_Fw_Grt;
  assign b_safe = (E_Fw_Grt == 32'd0) ? 32'd1 : b_mag;  // keeps the divider defined
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (!is_mult) begin
      if (E_Fw_Grt == 32'd0) begin
        res_hi = E_Fw_Grs;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = a_neg ? -r_mag : r_mag;
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      E_MD_busy <= 1'b0;
      cnt       <= 4'd0;
      hi_tmp    <= 32'd0;
      lo_tmp    <= 32'd0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (E_MD_start) begin
            hi_tmp    <= res_hi;
            lo_tmp    <= res_lo;
            cnt       <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            E_MD_busy <= 1'b1;
            state     <= RUN;
          end else if (E_MD_op == 4'd7) begin
            HI <= E_Fw_Grs;
          end else if (E_MD_op == 4'd8) begin
            LO <= E_Fw_Grs;
          end
        end
        RUN: begin
          // Every op presented while busy is ignored here.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            HI        <= hi_tmp;
            LO        <= lo_tmp;
            E_MD_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/e_md_unit.md
# e_md_unit

Execute-stage multiply/divide unit with architectural HI/LO registers. Sits in the E stage beside the ALU, takes forwarded rs/rt operands, and runs mult/multu/div/divu as fixed-latency multicycle operations. It drives `E_MD_start` and `E_MD_busy` to the hazard unit, which stalls any HI/LO-family instruction in D while either is high. It also serves mfhi/mflo reads and mthi/mtlo writes.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal 1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal 1..15).

- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `E_MD_op` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
- `E_Fw_Grs` input 32: forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- `E_Fw_Grt` input 32: forwarded rt value (divisor / multiplier).
- `E_MD_start` output 1: combinational; high when `E_MD_op` is 1-4 and `E_MD_busy`=0.
- `E_MD_busy` output 1: registered; high while an operation is in flight.
- `E_MD_out` output 32: combinational; HI for op 5, LO for op 6, else 0.
- `HI`, `LO` output 32 each: architectural registers.

## Operation
- State: `HI`, `LO`, `busy`, 4-bit `cnt`, 32-bit `hi_tmp`, 32-bit `lo_tmp`.
- FSM has two states. IDLE is busy=0; RUN is busy=1.
- IDLE with start: on the edge, compute the result into hi_tmp/lo_tmp from the current operands, load cnt with MULT_CYCLES or DIV_CYCLES, set busy=1. HI/LO are not yet changed.
- RUN: cnt decrements each edge. On the edge where cnt==1, commit HI<=hi_tmp and LO<=lo_tmp, and set busy<=0.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient/remainder.
- Divisor 0 (div or divu): LO=32'hFFFF_FFFF, HI=dividend.
- div of 32'h8000_0000 by 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- mthi/mtlo with busy=0: write HI or LO from `E_Fw_Grs` on the edge.
- Any op 1-4 or 7-8 presented while busy=1 is ignored: no state change, start stays 0. The hazard unit prevents this; the bench still checks it.
- mfhi/mflo while busy=1 return the old HI/LO. The hazard unit prevents this too.

## Timing
- Reset (asynchronous, active-low) clears HI, LO, hi_tmp, lo_tmp, cnt and busy to 0. Consequently `E_MD_out`=0 and `E_MD_start` follows `E_MD_op`.
- Reset mid-operation aborts the operation. No commit happens, and busy is 0 in the cycle after reset releases.
- Start seen in cycle T gives busy=1 in cycles T+1 through T+N, where N is the configured cycle count.
- HI/LO hold new values from cycle T+N+1. An mfhi/mflo in E during T+N+1 reads the new result.
- Back-to-back: a new start is accepted in T+N+1, the first cycle with busy=0.
- mthi/mtlo in cycle T: the new value is visible on HI/LO and `E_MD_out` in T+1.
- Operands are sampled only at the start edge. Changes to `E_Fw_Grs`/`E_Fw_Grt` during RUN have no effect.

## Test plan
- Reset held low mid-division (cnt=4) → HI=LO=0 and busy=0 immediately; the in-flight result is never committed after release.
- mult with rs=32'hFFFF_FFFE (-2), rt=3 → busy high exactly 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. multu with the same operands → HI=2, LO=32'hFFFF_FFFA.
- div with rs=-7, rt=2 → busy exactly 10 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. divu with rs=7, rt=0 → LO=32'hFFFF_FFFF, HI=7.
- mthi 32'h1234 in cycle T → HI=32'h1234 in T+1. An mflo in the next cycle returns the current LO on `E_MD_out`.
- mult started, then divu presented at busy cycle 3 with operands changed → start=0, and the committed result equals the original mult result.
- Two mults back-to-back, the second in the first non-busy cycle → second accepted; an mflo after it reads the second product.
